// File: rtl/polyvec_coeff_buffer.sv
// Polyvec coefficient buffer: captures the unpacked two-share word stream, checks
// range and completeness, then replays it one coefficient per handshake.
module polyvec_coeff_buffer #(
  parameter int unsigned KYBER_K = 2,
  parameter int unsigned KYBER_N = 256,
  parameter int unsigned LENGTH  = 128,
  parameter int unsigned LANE_W  = 16,
  parameter int unsigned COEFF_W = 12,
  parameter int unsigned KYBER_Q = 3329,
  parameter int unsigned DEPTH   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mux_enc_dec,
  input  logic               in_valid,
  input  logic [5:0]         in_addr,
  input  logic [LENGTH-1:0]  in_data1,
  input  logic [LENGTH-1:0]  in_data2,
  input  logic               in_done,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [8:0]         o_idx,
  output logic [COEFF_W-1:0] o_coeff_s1,
  output logic [COEFF_W-1:0] o_coeff_s2,
  output logic               o_last,
  output logic               busy,
  output logic               done,
  output logic               err_range,
  output logic               err_incomplete,
  output logic               err_overrun
);

  localparam int unsigned LANES  = LENGTH / LANE_W;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LANE_IW = $clog2(LANES);
  localparam int unsigned RD_W   = ADDR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;

  // A lane is out of range if its pad bits are set or the value reaches the modulus.
  function automatic logic range_bad(input lanes_t w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      if ((w[i][LANE_W-1:COEFF_W] != '0) || (w[i][COEFF_W-1:0] >= COEFF_W'(KYBER_Q)))
        bad = 1'b1;
    end
    return bad;
  endfunction

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic               r_mode;
  logic [DEPTH-1:0]   r_bitmap;
  logic [DEPTH-1:0]   w_bitmap_upd;
  lanes_t             r_mem1 [DEPTH];
  lanes_t             r_mem2 [DEPTH];

  lanes_t             r_word1;
  lanes_t             r_word2;
  logic [ADDR_W-1:0]  r_word_addr;
  logic               r_word_vld;
  logic [LANE_IW-1:0] r_lane;
  logic [RD_W-1:0]    r_rd_addr;

  logic w_accept;
  logic w_wr;
  logic w_fill_ok;
  logic w_fill_bad;
  logic w_hs;
  logic w_last_hs;
  logic w_enter_drain;
  logic w_fetch0;
  logic w_load;
  logic w_lane_last;
  logic w_more;
  logic w_rng;

  assign w_accept      = (r_state == ST_IDLE) && start;
  assign w_wr          = (r_state == ST_FILL) && in_valid;
  assign w_bitmap_upd  = r_bitmap | (w_wr ? (DEPTH'(1) << in_addr) : '0);
  assign w_fill_ok     = (r_state == ST_FILL) && in_done && (&w_bitmap_upd);
  assign w_fill_bad    = (r_state == ST_FILL) && in_done && !(&w_bitmap_upd);
  assign w_hs          = o_valid && o_ready;
  assign w_last_hs     = (r_state == ST_DRAIN) && w_hs && o_last;
  assign w_enter_drain = (r_state != ST_DRAIN) && (w_next_state == ST_DRAIN);
  assign w_fetch0      = (r_state == ST_DRAIN) && !r_word_vld && (r_rd_addr == '0);
  assign w_load        = (r_state == ST_DRAIN) && r_word_vld && (!o_valid || o_ready);
  assign w_lane_last   = (r_lane == LANE_IW'(LANES - 1));
  assign w_more        = (r_rd_addr != RD_W'(DEPTH));
  assign w_rng         = w_wr && (range_bad(in_data1) || (r_mode && range_bad(in_data2)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_FILL;
      ST_FILL: begin
        if (w_fill_ok)       w_next_state = ST_DRAIN;
        else if (w_fill_bad) w_next_state = ST_IDLE;
      end
      ST_DRAIN: if (w_last_hs) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Word storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem1[in_addr] <= in_data1;
      if (r_mode) r_mem2[in_addr] <= in_data2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= 1'b0;
      r_bitmap <= '0;
    end else if (w_accept) begin
      r_mode   <= mux_enc_dec;
      r_bitmap <= '0;
    end else if (w_wr) begin
      r_bitmap <= w_bitmap_upd;
    end
  end

  // Prefetch register: the next word is loaded on the edge that emits lane 7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word1     <= '0;
      r_word2     <= '0;
      r_word_addr <= '0;
      r_word_vld  <= 1'b0;
      r_lane      <= '0;
      r_rd_addr   <= '0;
    end else if (w_enter_drain) begin
      r_word_vld  <= 1'b0;
      r_lane      <= '0;
      r_rd_addr   <= '0;
    end else if (w_fetch0) begin
      r_word1     <= r_mem1[0];
      r_word2     <= r_mem2[0];
      r_word_addr <= '0;
      r_word_vld  <= 1'b1;
      r_lane      <= '0;
      r_rd_addr   <= RD_W'(1);
    end else if (w_load) begin
      r_lane <= r_lane + LANE_IW'(1);
      if (w_lane_last) begin
        if (w_more) begin
          r_word1     <= r_mem1[r_rd_addr[ADDR_W-1:0]];
          r_word2     <= r_mem2[r_rd_addr[ADDR_W-1:0]];
          r_word_addr <= r_rd_addr[ADDR_W-1:0];
          r_rd_addr   <= r_rd_addr + RD_W'(1);
        end else begin
          r_word_vld  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid        <= 1'b0;
      o_idx          <= '0;
      o_coeff_s1     <= '0;
      o_coeff_s2     <= '0;
      o_last         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_range      <= 1'b0;
      err_incomplete <= 1'b0;
      err_overrun    <= 1'b0;
    end else begin
      busy <= (w_next_state != ST_IDLE);
      done <= w_fill_bad || w_last_hs;
      if (w_load) begin
        o_valid    <= 1'b1;
        o_idx      <= {r_word_addr, r_lane};
        o_coeff_s1 <= r_word1[r_lane][COEFF_W-1:0];
        o_coeff_s2 <= r_mode ? r_word2[r_lane][COEFF_W-1:0] : '0;
        o_last     <= (r_word_addr == ADDR_W'(DEPTH - 1)) && w_lane_last;
      end else if (w_hs) begin
        o_valid    <= 1'b0;
        o_last     <= 1'b0;
      end
      // A start clears the sticky flags; a simultaneous new event still sets them.
      err_range      <= (w_accept ? 1'b0 : err_range) | w_rng;
      err_incomplete <= (w_accept ? 1'b0 : err_incomplete) | w_fill_bad;
      err_overrun    <= (w_accept ? 1'b0 : err_overrun) | (in_valid && (r_state != ST_FILL));
    end
  end

endmodule

// File: tb/tb_polyvec_coeff_buffer.sv
// Directed bench for polyvec_coeff_buffer: fill/drain in both modes, backpressure,
// range/incomplete/overrun flags and asynchronous reset mid-drain.
module tb_polyvec_coeff_buffer;

  typedef logic [7:0][15:0] word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mux_enc_dec;
  logic        in_valid;
  logic [5:0]  in_addr;
  logic [127:0] in_data1;
  logic [127:0] in_data2;
  logic        in_done;
  logic        o_valid;
  logic        o_ready;
  logic [8:0]  o_idx;
  logic [11:0] o_coeff_s1;
  logic [11:0] o_coeff_s2;
  logic        o_last;
  logic        busy;
  logic        done;
  logic        err_range;
  logic        err_incomplete;
  logic        err_overrun;

  int errors = 0;
  int checks = 0;

  word_t       w1 [64];
  word_t       w2 [64];
  logic [11:0] e1 [512];
  logic [11:0] e2 [512];
  logic [11:0] c43;

  always #5 clk = ~clk;

  polyvec_coeff_buffer dut (
    .clk(clk), .rst(rst), .start(start), .mux_enc_dec(mux_enc_dec),
    .in_valid(in_valid), .in_addr(in_addr), .in_data1(in_data1), .in_data2(in_data2),
    .in_done(in_done), .o_valid(o_valid), .o_ready(o_ready), .o_idx(o_idx),
    .o_coeff_s1(o_coeff_s1), .o_coeff_s2(o_coeff_s2), .o_last(o_last),
    .busy(busy), .done(done), .err_range(err_range),
    .err_incomplete(err_incomplete), .err_overrun(err_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane value 8*addr+lane; share 2 is 3328-share1 (dec) or all ones (enc, ignored).
  task automatic make_ramp(input bit dec);
    for (int a = 0; a < 64; a++) begin
      for (int l = 0; l < 8; l++) begin
        w1[a][l] = 16'(8 * a + l);
        w2[a][l] = dec ? 16'(3328 - (8 * a + l)) : 16'hFFFF;
      end
    end
  endtask

  task automatic calc_exp(input bit dec);
    for (int a = 0; a < 64; a++) begin
      for (int l = 0; l < 8; l++) begin
        e1[8 * a + l] = w1[a][l][11:0];
        e2[8 * a + l] = dec ? w2[a][l][11:0] : 12'h000;
      end
    end
  endtask

  task automatic do_start(input bit m);
    mux_enc_dec = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic fill(input bit rev, input int skip, input bit merge_done);
    for (int i = 0; i < 64; i++) begin
      int a;
      a = rev ? 63 - i : i;
      if (a != skip) begin
        in_valid = 1'b1;
        in_addr  = 6'(a);
        in_data1 = w1[a];
        in_data2 = w2[a];
        if (merge_done && i == 63) in_done = 1'b1;
        tick();
      end
    end
    in_valid = 1'b0;
    in_done  = 1'b0;
  endtask

  task automatic send_done();
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
  endtask

  task automatic drain(input bit bp, output logic [11:0] cap43);
    int n, cyc, bad, unstable, scnt;
    logic [8:0]  last_i, h_idx;
    logic [11:0] h1, h2;
    logic        h_last, rdy;
    bit          held;
    n = 0; cyc = 0; bad = 0; unstable = 0; scnt = 0;
    last_i = 9'h1FF; held = 1'b0; cap43 = '0;
    h_idx = '0; h1 = '0; h2 = '0; h_last = 1'b0;
    while (n < 512 && cyc < 4000) begin
      if (held && (!o_valid || o_idx !== h_idx || o_coeff_s1 !== h1 ||
                   o_coeff_s2 !== h2 || o_last !== h_last))
        unstable++;
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bp && o_valid) begin
        if (o_idx != last_i) begin
          last_i = o_idx;
          scnt = 0;
        end
        if ((o_idx == 9'd7 || o_idx == 9'd8 || o_idx == 9'd503 || o_idx == 9'd504) && scnt < 2) begin
          rdy = 1'b0;
          scnt++;
        end
      end
      o_ready = rdy;
      held   = o_valid && !rdy;
      h_idx  = o_idx;
      h1     = o_coeff_s1;
      h2     = o_coeff_s2;
      h_last = o_last;
      if (o_valid && rdy) begin
        if (o_idx !== 9'(n) || o_coeff_s1 !== e1[n] || o_coeff_s2 !== e2[n] || o_last !== (n == 511))
          bad++;
        if (n == 43) cap43 = o_coeff_s1;
        n++;
      end
      tick();
      cyc++;
    end
    o_ready = 1'b0;
    chk("drain_count", 32'(n), 32'd512);
    chk("drain_data", 32'(bad), 32'd0);
    chk("drain_stable", 32'(unstable), 32'd0);
    chk("end_valid", 32'(o_valid), 32'd0);
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; mux_enc_dec = 1'b0; in_valid = 1'b0; in_addr = '0;
    in_data1 = '0; in_data2 = '0; in_done = 1'b0; o_ready = 1'b0; c43 = '0;
    tick(); tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_idx", 32'(o_idx), 32'd0);
    chk("rst_s1", 32'(o_coeff_s1), 32'd0);
    chk("rst_s2", 32'(o_coeff_s2), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err_range", 32'(err_range), 32'd0);
    chk("rst_err_incomplete", 32'(err_incomplete), 32'd0);
    chk("rst_err_overrun", 32'(err_overrun), 32'd0);
    rst = 1'b0;
    tick();

    // Enc, in-order fill, last word together with in_done.
    make_ramp(1'b0); calc_exp(1'b0);
    do_start(1'b0);
    fill(1'b0, -1, 1'b1);
    chk("enc_err_range", 32'(err_range), 32'd0);
    chk("enc_err_incomplete", 32'(err_incomplete), 32'd0);
    chk("enc_err_overrun", 32'(err_overrun), 32'd0);
    drain(1'b0, c43);

    // Dec, reverse-order fill; first o_valid exactly two cycles after in_done.
    make_ramp(1'b1); calc_exp(1'b1);
    do_start(1'b1);
    fill(1'b1, -1, 1'b0);
    send_done();
    chk("dec_valid_lat0", 32'(o_valid), 32'd0);
    tick();
    chk("dec_valid_lat1", 32'(o_valid), 32'd0);
    tick();
    chk("dec_valid_lat2", 32'(o_valid), 32'd1);
    chk("dec_err_range", 32'(err_range), 32'd0);
    drain(1'b0, c43);

    // Backpressure with forced stalls at word boundaries.
    do_start(1'b1);
    fill(1'b0, -1, 1'b0);
    send_done();
    drain(1'b1, c43);

    // Range: 3329 in word 5 lane 3 is stored but flagged.
    make_ramp(1'b0); w1[5][3] = 16'h0D01; calc_exp(1'b0);
    do_start(1'b0);
    fill(1'b0, -1, 1'b0);
    chk("rangeA_err", 32'(err_range), 32'd1);
    send_done();
    drain(1'b0, c43);
    chk("rangeA_coeff43", 32'(c43), 32'h0D01);
    chk("rangeA_sticky", 32'(err_range), 32'd1);

    // Range: pad bits set in word 5 lane 0.
    make_ramp(1'b0); w1[5][0] = 16'h1001; calc_exp(1'b0);
    do_start(1'b0);
    chk("rangeB_cleared", 32'(err_range), 32'd0);
    fill(1'b0, -1, 1'b0);
    chk("rangeB_err", 32'(err_range), 32'd1);
    send_done();
    drain(1'b0, c43);

    // Incomplete fill (address 17 missing), then overrun in IDLE.
    make_ramp(1'b0); calc_exp(1'b0);
    do_start(1'b0);
    fill(1'b0, 17, 1'b0);
    send_done();
    chk("inc_err", 32'(err_incomplete), 32'd1);
    chk("inc_done", 32'(done), 32'd1);
    chk("inc_busy", 32'(busy), 32'd0);
    chk("inc_valid", 32'(o_valid), 32'd0);
    tick();
    chk("inc_done_pulse", 32'(done), 32'd0);
    tick();
    chk("inc_no_valid", 32'(o_valid), 32'd0);
    in_valid = 1'b1; in_addr = 6'd3;
    tick();
    in_valid = 1'b0;
    chk("ovr_err", 32'(err_overrun), 32'd1);
    chk("ovr_inc_sticky", 32'(err_incomplete), 32'd1);
    do_start(1'b0);
    chk("start_clr_inc", 32'(err_incomplete), 32'd0);
    chk("start_clr_ovr", 32'(err_overrun), 32'd0);

    // Async reset mid-drain at o_idx 200.
    fill(1'b0, -1, 1'b0);
    send_done();
    o_ready = 1'b1;
    cyc = 0;
    while (!(o_valid && o_idx == 9'd200) && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk("reach_idx200", 32'(o_idx), 32'd200);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_idx", 32'(o_idx), 32'd0);
    chk("arst_s1", 32'(o_coeff_s1), 32'd0);
    chk("arst_last", 32'(o_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    o_ready = 1'b0;
    tick(); tick();
    chk("post_rst_valid", 32'(o_valid), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    make_ramp(1'b1); calc_exp(1'b1);
    do_start(1'b1);
    fill(1'b0, -1, 1'b0);
    send_done();
    drain(1'b0, c43);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/polyvec_coeff_buffer.md
Name: polyvec_coeff_buffer

Overview:
- Sits directly downstream of the pk/sk unpack stage and captures its word stream.
- Input is 64 words × 128 bits, with 8 coefficients of 12 bits each carried in 16-bit lanes, and two masked shares.
- Stores the stream in a double-share word buffer, checks coefficient range and completeness, then replays it as a per-coefficient stream with a valid/ready handshake.
- The consumer is the NTT/poly-arith engine that consumes polyvec coefficients.

Parameters:
- KYBER_K, 2, polynomials per vector
- KYBER_N, 256, coefficients per polynomial
- LENGTH, 128, input word width
- LANE_W, 16, lane width inside a word
- COEFF_W, 12, coefficient width
- KYBER_Q, 3329, modulus used for range check
- DEPTH, 64, words buffered; equals KYBER_K*KYBER_N*LANE_W/LENGTH

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; arms the buffer for a new vector
- mux_enc_dec  in  1  sampled at start; 0 = enc (share 2 ignored, output as 0), 1 = dec (both shares)
- in_valid  in  1  word strobe from the unpack stage
- in_addr  in  6  word address, 0..63
- in_data1  in  LENGTH  share-1 word; lane i is bits [16i+11:16i]
- in_data2  in  LENGTH  share-2 word, same layout
- in_done  in  1  one-cycle pulse; unpack stage finished
- o_valid  out  1  coefficient available
- o_ready  in  1  consumer accepts
- o_idx  out  9  coefficient index 0..511
- o_coeff_s1  out  COEFF_W  share-1 coefficient
- o_coeff_s2  out  COEFF_W  share-2 coefficient
- o_last  out  1  high with o_idx = 511
- busy  out  1  high in FILL or DRAIN
- done  out  1  one-cycle pulse at end of operation
- err_range  out  1  sticky: a lane ≥ KYBER_Q, or lane bits [15:12] ≠ 0
- err_incomplete  out  1  sticky: in_done arrived with unwritten words
- err_overrun  out  1  sticky: in_valid seen outside FILL

Behaviour:
- Reset (async, any state): state = IDLE. All outputs are 0, the written-bitmap is 0, and all flags are 0. Buffer contents are don't-care.
- States: IDLE, FILL, DRAIN.
- IDLE:
  - start → FILL.
  - On the same edge: clear the bitmap and all three err flags, and latch mux_enc_dec.
  - in_valid in IDLE sets err_overrun; no write happens.
- FILL:
  - Each in_valid writes in_data1 (and in_data2 if dec) to in_addr and sets bitmap[in_addr].
  - A repeated address overwrites the word; this is not an error.
  - Range check on every written word, all 8 lanes of each active share: lane[15:12] ≠ 0 or lane[11:0] ≥ 3329 sets err_range. The word is still stored.
  - in_done with bitmap all ones → DRAIN.
  - in_done with any bitmap bit 0 → set err_incomplete, pulse done, → IDLE with no drain.
  - in_valid and in_done in the same cycle: the word is written and counted first, then the completeness check is made.
  - start in FILL is ignored.
- DRAIN:
  - Coefficient order: word 0 lane 0, lane 1 … lane 7, then word 1 … word 63 lane 7. o_idx = 8·word + lane.
  - First o_valid rises exactly 2 cycles after the in_done edge.
  - Output registers hold stable while o_valid && !o_ready.
  - On each o_valid && o_ready, advance to the next coefficient.
  - With o_ready held high, throughput is 1 coefficient/cycle with no bubbles at word boundaries, so the next word must be prefetched.
  - o_coeff_s2 = 0 in enc mode.
  - Handshake at o_idx = 511: o_valid drops the next cycle, done pulses that same cycle, → IDLE.
  - in_valid during DRAIN sets err_overrun and is ignored.
  - start during DRAIN is ignored.
- busy = (state ≠ IDLE).
- Err flags stay sticky until the next accepted start. err_range does not stop the drain.
- Reset mid-FILL/DRAIN aborts immediately. No done pulse is produced and no further coefficients are emitted.

Test Plan:
- Enc fill: start with mux_enc_dec = 0, then 64 words with lane value = 8·addr + lane, addresses in order, then in_done → o_idx 0..511 with o_coeff_s1 = o_idx and s2 = 0; o_last at 511; done one cycle after the last handshake; no errors.
- Dec, out-of-order fill: write addresses in reverse order; share 2 = 3328 − share 1 → stream ordered by o_idx, both shares correct, o_valid exactly 2 cycles after in_done.
- Backpressure: toggle o_ready pseudo-randomly during drain, with stalls on word boundaries 7→8 and 503→504 → no coefficient dropped or duplicated; outputs stable while stalled.
- Range error: word 5 lane 3 = 0x0D01 (3329), and separately lane 0 = 0x1001 → err_range = 1; the drain still delivers 512 coefficients, with coefficient 43 = 0xD01.
- Incomplete/overrun: omit address 17 then assert in_done → err_incomplete = 1 and done pulse with no o_valid; then in_valid while IDLE → err_overrun = 1; the next start clears both.
- Async reset at o_idx = 200 mid-drain → all outputs 0 immediately; a fresh start plus full fill then drains correctly from o_idx 0.
